// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
// WIDTH-bit adder/subtractor that walks the operands one nibble per cycle
// through a single 4-bit carry-lookahead slice. It has a ready/valid request
// port and a ready/valid result port. A three-state controller sequences the
// nibble steps. Subtraction is done as A + ~B + 1: B is inverted when the
// request is accepted, and the carry chain is seeded with 1.

// ---------------------------------------------------------------------------
// cla_4bit: one 4-bit carry-lookahead slice with flat (non-rippled) carries.
// ---------------------------------------------------------------------------
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    // Generate/propagate terms, two-level lookahead carries, sum bits
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// ---------------------------------------------------------------------------
// nibble_serial_add_ctrl: controller plus the serial datapath around one slice.
// ---------------------------------------------------------------------------
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int MSB   = WIDTH - 1;
    // Keep the index at least one bit wide so that WIDTH=4 still elaborates.
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic             sub_q,   sub_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;

    logic [3:0] slice_a;
    logic [3:0] slice_b;
    logic [3:0] slice_sum;
    logic       slice_cout;
    logic       accept;
    logic       result_valid;

    // sub_q records the operation type for debug visibility only. The
    // datapath already carries that information in b_q and in the carry seed.
    logic unused_sub;
    assign unused_sub = sub_q;

    // The one and only adder: the current nibble of A and B plus the running carry
    cla_4bit u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Nibble select mux: pick operand nibbles idx_q out of the held words
    always_comb begin
        slice_a = 4'd0;
        slice_b = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[4*i +: 4];
                slice_b = b_q[4*i +: 4];
            end
        end
    end

    // Next-state and datapath update; flush overrides every other action
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        accept  = 1'b0;

        if (flush) begin
            state_d = IDLE;
            idx_d   = '0;
            carry_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        accept  = 1'b1;
                        a_d     = a;
                        b_d     = sub ? ~b : b;
                        sub_d   = sub;
                        carry_d = sub;
                        idx_d   = '0;
                        sum_d   = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            sum_d[4*i +: 4] = slice_sum;
                        end
                    end
                    carry_d = slice_cout;
                    // The last nibble returns the index to zero rather than
                    // letting it step past NIB-1.
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    carry_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with immediate (asynchronous) reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

    // Output decode: result fields are forced to zero outside DONE
    always_comb begin
        result_valid = (state_q == DONE);
        in_ready     = (state_q == IDLE);
        busy         = (state_q != IDLE);
        out_valid    = result_valid;
        sum          = '0;
        cout         = 1'b0;
        ovf          = 1'b0;
        if (result_valid) begin
            sum  = sum_q;
            cout = carry_q;
            // Signed overflow: both addends (B after inversion) have the same
            // sign, and the result sign differs from it.
            ovf  = (a_q[MSB] == b_q[MSB]) && (sum_q[MSB] != a_q[MSB]);
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed and randomized checks for nibble_serial_add_ctrl at WIDTH=4, 16, 64.
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4, busy4;
    logic [3:0]  a4, b4, sum4;
    logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, cout16, ovf16, busy16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid64, in_ready64, sub64, out_valid64, out_ready64, cout64, ovf64, busy64;
    logic [63:0] a64, b64, sum64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4), .sub(sub4),
        .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4),
        .cout(cout4), .ovf(ovf4), .busy(busy4)
    );

    nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16), .sum(sum16),
        .cout(cout16), .ovf(ovf16), .busy(busy16)
    );

    nibble_serial_add_ctrl #(.WIDTH(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .a(a64), .b(b64), .sub(sub64),
        .out_valid(out_valid64), .out_ready(out_ready64), .sum(sum64),
        .cout(cout64), .ovf(ovf64), .busy(busy64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-instance accessors for the randomized test (sel: 0=W4, 1=W16, 2=W64)
    function automatic logic get_ov(int sel);
        case (sel)
            0:       return out_valid4;
            1:       return out_valid16;
            default: return out_valid64;
        endcase
    endfunction

    function automatic logic get_ir(int sel);
        case (sel)
            0:       return in_ready4;
            1:       return in_ready16;
            default: return in_ready64;
        endcase
    endfunction

    function automatic logic [65:0] get_res(int sel);
        case (sel)
            0:       return {60'd0, sum4, cout4, ovf4};
            1:       return {48'd0, sum16, cout16, ovf16};
            default: return {sum64, cout64, ovf64};
        endcase
    endfunction

    task automatic drive_in(int sel, logic v, logic [63:0] av, logic [63:0] bv, logic s);
        case (sel)
            0: begin in_valid4 = v; a4 = av[3:0]; b4 = bv[3:0]; sub4 = s; end
            1: begin in_valid16 = v; a16 = av[15:0]; b16 = bv[15:0]; sub16 = s; end
            default: begin in_valid64 = v; a64 = av; b64 = bv; sub64 = s; end
        endcase
    endtask

    task automatic set_ready(int sel, logic r);
        case (sel)
            0:       out_ready4 = r;
            1:       out_ready16 = r;
            default: out_ready64 = r;
        endcase
    endtask

    // Issue one request to the 16-bit DUT, wait for its result, then consume it.
    // The operand inputs are scrambled right after acceptance.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic s,
                        output logic [15:0] rs, output logic rc, output logic ro,
                        output int lat, output logic after_ov);
        out_ready16 = 1'b0;
        a16 = av; b16 = bv; sub16 = s; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0; a16 = ~av; b16 = ~bv; sub16 = ~s;
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        rs = sum16; rc = cout16; ro = ovf16;
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        after_ov = out_valid16;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready16, busy16, out_valid16} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/busy/valid=%b required 100", {in_ready16, busy16, out_valid16});
        end
        checks++;
        if ({sum16, cout16, ovf16} !== 18'd0) begin
            errors++;
            $display("FAIL reset_result: got sum=%h cout=%b ovf=%b required 0", sum16, cout16, ovf16);
        end
        checks++;
        if ({in_ready4, busy4, in_ready64, busy64} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_other: got %b required 1010", {in_ready4, busy4, in_ready64, busy64});
        end
        tick();
        rst_n = 1'b1;
        $display("reset: checked idle outputs");
    endtask

    task automatic test_add();
        logic [15:0] rs; logic rc, ro, aft; int lat;
        op16(16'h1234, 16'h0FCD, 1'b0, rs, rc, ro, lat, aft);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL add_latency: got %0d required 4", lat); end
        checks++;
        if ({rs, rc, ro} !== {16'h2201, 1'b0, 1'b0}) begin
            errors++; $display("FAIL add_result: got sum=%h c=%b v=%b required 2201 0 0", rs, rc, ro);
        end
        checks++;
        if (aft !== 1'b0) begin errors++; $display("FAIL add_drop: out_valid=%b required 0", aft); end
        $display("add: 1234+0FCD -> %h c=%b v=%b lat=%0d", rs, rc, ro, lat);
    endtask

    task automatic test_carry();
        logic [15:0] rs; logic rc, ro, aft; int lat;
        op16(16'hFFFF, 16'h0001, 1'b0, rs, rc, ro, lat, aft);
        checks++;
        if ({rs, rc, ro} !== {16'h0000, 1'b1, 1'b0}) begin
            errors++; $display("FAIL carry_wrap: got sum=%h c=%b v=%b required 0000 1 0", rs, rc, ro);
        end
        $display("carry: FFFF+0001 -> %h c=%b v=%b", rs, rc, ro);
        op16(16'h7FFF, 16'h0001, 1'b0, rs, rc, ro, lat, aft);
        checks++;
        if ({rs, rc, ro} !== {16'h8000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL carry_ovf: got sum=%h c=%b v=%b required 8000 0 1", rs, rc, ro);
        end
        $display("carry: 7FFF+0001 -> %h c=%b v=%b", rs, rc, ro);
    endtask

    task automatic test_sub();
        logic [15:0] rs; logic rc, ro, aft; int lat;
        op16(16'h0005, 16'h0007, 1'b1, rs, rc, ro, lat, aft);
        checks++;
        if ({rs, rc, ro} !== {16'hFFFE, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sub_borrow: got sum=%h c=%b v=%b required FFFE 0 0", rs, rc, ro);
        end
        $display("sub: 0005-0007 -> %h c=%b v=%b", rs, rc, ro);
        op16(16'h8000, 16'h0001, 1'b1, rs, rc, ro, lat, aft);
        checks++;
        if ({rs, rc, ro} !== {16'h7FFF, 1'b1, 1'b1}) begin
            errors++; $display("FAIL sub_ovf: got sum=%h c=%b v=%b required 7FFF 1 1", rs, rc, ro);
        end
        $display("sub: 8000-0001 -> %h c=%b v=%b", rs, rc, ro);
    endtask

    task automatic test_back_to_back();
        int lat; int bad;
        out_ready16 = 1'b0;
        a16 = 16'h1111; b16 = 16'h2222; sub16 = 1'b0; in_valid16 = 1'b1;
        tick();
        // Second request stays pending for the whole first operation
        a16 = 16'h0100; b16 = 16'h0200; sub16 = 1'b0;
        checks++;
        if (sum16 !== 16'h0000) begin errors++; $display("FAIL bp_zero_in_run: sum=%h required 0000", sum16); end
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL bp_latency: got %0d required 4", lat); end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            if ({out_valid16, in_ready16, sum16, cout16, ovf16} !== {1'b1, 1'b0, 16'h3333, 1'b0, 1'b0}) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad); end
        checks++;
        if ({out_valid16, sum16} !== {1'b1, 16'h3333}) begin
            errors++; $display("FAIL bp_still_valid: got v=%b sum=%h required 1 3333", out_valid16, sum16);
        end
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        checks++;
        if ({out_valid16, in_ready16, busy16} !== 3'b010) begin
            errors++; $display("FAIL bp_after_hs: got valid/ready/busy=%b required 010", {out_valid16, in_ready16, busy16});
        end
        tick();
        in_valid16 = 1'b0;
        checks++;
        if (busy16 !== 1'b1) begin errors++; $display("FAIL bp_second_accept: busy=%b required 1", busy16); end
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 20) begin tick(); lat++; end
        checks++;
        if ({lat == 4, sum16} !== {1'b1, 16'h0300}) begin
            errors++; $display("FAIL bp_second_result: got sum=%h lat=%0d required 0300 lat 4", sum16, lat);
        end
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        $display("back_to_back: held 5 cycles, second result %h", 16'h0300);
    endtask

    task automatic test_flush();
        int seen;
        a16 = 16'hAAAA; b16 = 16'h5555; sub16 = 1'b0; in_valid16 = 1'b1; out_ready16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        checks++;
        if ({busy16, in_ready16, out_valid16, sum16} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            errors++; $display("FAIL flush_run: got busy=%b ready=%b valid=%b sum=%h required 0 1 0 0000",
                               busy16, in_ready16, out_valid16, sum16);
        end
        in_valid16 = 1'b1;
        tick();
        checks++;
        if (busy16 !== 1'b0) begin errors++; $display("FAIL flush_over_accept: busy=%b required 0", busy16); end
        flush = 1'b0; in_valid16 = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (out_valid16 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_result: valid seen %0d times required 0", seen); end
        // Flush in DONE beats a same-cycle out_ready
        out_ready16 = 1'b0;
        a16 = 16'h0003; b16 = 16'h0004; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        repeat (4) tick();
        flush = 1'b1; out_ready16 = 1'b1;
        tick();
        flush = 1'b0; out_ready16 = 1'b0;
        checks++;
        if ({out_valid16, sum16, busy16} !== {1'b0, 16'h0000, 1'b0}) begin
            errors++; $display("FAIL flush_done: got valid=%b sum=%h busy=%b required 0 0000 0",
                               out_valid16, sum16, busy16);
        end
        $display("flush: aborted in RUN and in DONE");
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] rs; logic rc, ro, aft; int lat;
        a16 = 16'h0F0F; b16 = 16'h0101; sub16 = 1'b0; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy16, in_ready16, out_valid16, sum16, cout16, ovf16} !== {3'b010, 18'd0}) begin
            errors++; $display("FAIL reset_async: got busy=%b ready=%b valid=%b sum=%h required 0 1 0 0000",
                               busy16, in_ready16, out_valid16, sum16);
        end
        tick();
        rst_n = 1'b1;
        op16(16'h0001, 16'h0001, 1'b0, rs, rc, ro, lat, aft);
        checks++;
        if ({rs, rc, ro, lat == 4} !== {16'h0002, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_recover: got sum=%h lat=%0d required 0002 lat 4", rs, lat);
        end
        $display("reset_mid_run: recovered, 0001+0001 -> %h", rs);
    endtask

    task automatic test_random(int sel, int w, int n);
        logic [63:0] mask, av, bv, bb, exp_sum;
        logic [64:0] full;
        logic s, exp_c, exp_o, r, ov_before, hs;
        int nib, cyc, first;
        nib = w / 4;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        for (int t = 0; t < n; t++) begin
            av = {$urandom(), $urandom()} & mask;
            bv = {$urandom(), $urandom()} & mask;
            s = 1'($urandom_range(0, 1));
            bb = (s ? ~bv : bv) & mask;
            full = {1'b0, av} + {1'b0, bb} + {64'd0, s};
            exp_sum = full[63:0] & mask;
            exp_c = full[w];
            exp_o = (av[w-1] == bb[w-1]) && (exp_sum[w-1] != av[w-1]);
            repeat ($urandom_range(0, 2)) tick();
            checks++;
            if (get_ir(sel) !== 1'b1) begin errors++; $display("FAIL rnd%0d_ready: in_ready=0 required 1", w); end
            drive_in(sel, 1'b1, av, bv, s);
            tick();
            drive_in(sel, 1'b0, ~av, ~bv, ~s);
            cyc = 0; first = -1; hs = 1'b0;
            while (!hs && cyc < nib + 40) begin
                r = 1'($urandom_range(0, 1));
                set_ready(sel, r);
                ov_before = get_ov(sel);
                tick();
                cyc++;
                if (ov_before && r) begin
                    hs = 1'b1;
                    checks++;
                    if (get_ov(sel) !== 1'b0) begin errors++; $display("FAIL rnd%0d_drop: out_valid=1 required 0", w); end
                end else if (get_ov(sel) === 1'b1 && first < 0) begin
                    first = cyc;
                    checks++;
                    if (first != nib) begin errors++; $display("FAIL rnd%0d_latency: got %0d required %0d", w, first, nib); end
                    checks++;
                    if (get_res(sel) !== {exp_sum, exp_c, exp_o}) begin
                        errors++;
                        $display("FAIL rnd%0d_result: a=%h b=%h sub=%b got %h required sum=%h c=%b v=%b",
                                 w, av, bv, s, get_res(sel), exp_sum, exp_c, exp_o);
                    end
                end
            end
            set_ready(sel, 1'b0);
            if (!hs) begin
                checks++; errors++;
                $display("FAIL rnd%0d_timeout: no result handshake within %0d cycles", w, nib + 40);
            end
            $display("random W=%0d: a=%h b=%h sub=%b expect sum=%h c=%b v=%b", w, av, bv, s, exp_sum, exp_c, exp_o);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
        in_valid64 = 1'b0; out_ready64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0;
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_random(0, 4, 8);
        test_random(1, 16, 8);
        test_random(2, 64, 8);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
